// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// Covers the arbiter state encoding and the nominal frame timing.
package uart_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int CLK_FREQ   = 50_000_000;
  localparam int BAUD_RATE  = 9600;
  // One 11-bit frame using the integer baud divider.
  localparam int FRAME_CYCLES = 11 * (CLK_FREQ / BAUD_RATE);
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, searched cyclically
// through a doubled copy of the request vector.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 any,
  output logic [$clog2(N)-1:0] idx
);
  localparam int ID_W = $clog2(N);
  localparam int DW   = $clog2(2 * N);

  logic [2*N-1:0] dbl;
  logic [DW-1:0]  pos;

  assign dbl = {req, req};

  always_comb begin
    any = 1'b0;
    idx = '0;
    pos = '0;
    for (int i = 0; i < N; i++) begin
      pos = DW'(ptr) + DW'(i);
      if (!any && dbl[pos]) begin
        any = 1'b1;
        idx = ID_W'((pos >= DW'(N)) ? pos - DW'(N) : pos);
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX core among N requesters, byte by byte, with packet lock,
// a per-grant burst cap and a per-frame watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N              = 4,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int MAX_BURST      = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [N*DATA_W-1:0]   req_data,
  input  logic [N-1:0]          req_last,
  output logic [N-1:0]          req_ack,
  output logic                  tx_start,
  output logic [DATA_W-1:0]     tx_data,
  input  logic                  tx_busy,
  input  logic                  tx_done,
  output logic                  grant_valid,
  output logic [$clog2(N)-1:0]  grant_id,
  output logic                  err_timeout,
  input  logic                  err_clr
);
  localparam int ID_W    = $clog2(N);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
  localparam logic [WD_W-1:0]    WD_LIMIT  = WD_W'(TIMEOUT_CYCLES - 1);

  state_t              state_q, state_n;
  logic [ID_W-1:0]     ptr_q, ptr_n, gid_n, pick_idx, next_ptr;
  logic                pick_any, gv_n, start_n, err_n, release_gnt;
  logic                last_q, last_n, req_sel, last_sel;
  logic [N-1:0]        ack_n;
  logic [DATA_W-1:0]   data_n, data_sel;
  logic [BURST_W-1:0]  burst_q, burst_n;
  logic [WD_W-1:0]     wd_q, wd_n;

  rr_pick #(.N(N)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign next_ptr = (grant_id == ID_W'(N - 1)) ? '0 : grant_id + ID_W'(1);

  always_comb begin
    req_sel  = 1'b0;
    last_sel = 1'b0;
    data_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_id == ID_W'(i)) begin
        req_sel  = req[i];
        last_sel = req_last[i];
        data_sel = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_n     = state_q;
    gid_n       = grant_id;
    gv_n        = grant_valid;
    ptr_n       = ptr_q;
    burst_n     = burst_q;
    wd_n        = wd_q;
    start_n     = 1'b0;
    ack_n       = '0;
    data_n      = tx_data;
    last_n      = last_q;
    err_n       = err_timeout & ~err_clr;
    release_gnt = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gid_n   = pick_idx;
          gv_n    = 1'b1;
          burst_n = '0;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        // A requester that withdrew before its byte went out loses the grant.
        if (!req_sel) begin
          release_gnt = 1'b1;
        end else if (!tx_busy) begin
          start_n         = 1'b1;
          ack_n[grant_id] = 1'b1;
          data_n          = data_sel;
          last_n          = last_sel;
          burst_n         = burst_q + BURST_W'(1);
          wd_n            = '0;
          state_n         = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        wd_n = wd_q + WD_W'(1);
        if (tx_done) begin
          if (!last_q && (burst_q < BURST_MAX) && req_sel) state_n = ISSUE;
          else release_gnt = 1'b1;
        end else if (wd_q == WD_LIMIT) begin
          err_n       = 1'b1;
          release_gnt = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (release_gnt) begin
      gv_n    = 1'b0;
      ptr_n   = next_ptr;
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      ptr_q       <= '0;
      burst_q     <= '0;
      wd_q        <= '0;
      tx_start    <= 1'b0;
      req_ack     <= '0;
      tx_data     <= '0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_n;
      grant_id    <= gid_n;
      grant_valid <= gv_n;
      ptr_q       <= ptr_n;
      burst_q     <= burst_n;
      wd_q        <= wd_n;
      tx_start    <= start_n;
      req_ack     <= ack_n;
      tx_data     <= data_n;
      err_timeout <= err_n;
    end
  end

  always_ff @(posedge clk) begin
    last_q <= last_n;
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a TX core model and a
// frame-level reference model feeding a scoreboard.
module tb_uart_tx_arbiter;
  localparam int N         = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;
  localparam int TIMEOUT   = 100;
  localparam int DEPTH     = 16;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req;
  logic [N*DATA_W-1:0] req_data;
  logic [N-1:0]        req_last;
  logic [N-1:0]        req_ack;
  logic                tx_start;
  logic [DATA_W-1:0]   tx_data;
  logic                tx_busy;
  logic                tx_done;
  logic                grant_valid;
  logic [1:0]          grant_id;
  logic                err_timeout;
  logic                err_clr;

  logic [8:0] mem [N][DEPTH];
  int   head [N];
  int   tail [N];
  exp_t exp_q [$];
  int   mptr = 0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   load_cyc = 0;
  int   start_cyc = 0;
  bit   had_req = 0;
  bit   tx_hang = 0;

  uart_tx_arbiter #(
    .N(N), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .req_ack(req_ack), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .tx_done(tx_done), .grant_valid(grant_valid), .grant_id(grant_id),
    .err_timeout(err_timeout), .err_clr(err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input int i, input logic [7:0] d, input logic last);
    mem[i][tail[i]] = {last, d};
    tail[i]++;
  endtask

  function automatic bit drained();
    for (int i = 0; i < N; i++) if (head[i] != tail[i]) return 0;
    return 1;
  endfunction

  // Reference: whole frames per grant, decided from the queued bytes only.
  task automatic model_round();
    int h [N];
    int pick, sent;
    logic [8:0] b;
    for (int i = 0; i < N; i++) h[i] = head[i];
    forever begin
      pick = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (mptr + k) % N;
        if (pick < 0 && h[j] < tail[j]) pick = j;
      end
      if (pick < 0) break;
      sent = 0;
      forever begin
        b = mem[pick][h[pick]];
        h[pick]++;
        sent++;
        exp_q.push_back('{id: 2'(pick), data: b[7:0]});
        if (b[8] || sent >= MAX_BURST || h[pick] >= tail[pick]) break;
      end
      mptr = (pick + 1) % N;
    end
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (n < budget && !(exp_q.size() == 0 && drained() && !grant_valid && !tx_busy)) begin
      @(posedge clk); #3;
      n++;
    end
    check("drain_in_budget", (n < budget) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Requesters: present the head byte, pop it on acknowledge.
  initial begin
    req = '0; req_data = '0; req_last = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (req_ack[i] && head[i] < tail[i]) head[i]++;
        if (head[i] < tail[i]) begin
          req[i] = 1'b1;
          req_data[i*DATA_W +: DATA_W] = mem[i][head[i]][7:0];
          req_last[i] = mem[i][head[i]][8];
        end else begin
          req[i] = 1'b0;
          req_data[i*DATA_W +: DATA_W] = 8'($urandom);
          req_last[i] = 1'($urandom);
        end
      end
      if (req != '0 && !had_req) load_cyc = cyc;
      had_req = (req != '0);
    end
  end

  // TX core: busy from start, done after a few cycles, optional busy tail.
  initial begin
    tx_busy = 1'b0; tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tx_start && !tx_hang) begin
        tx_busy = 1'b1;
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // Monitor: every issued byte must match the next expected frame.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (!rst && (tx_start || req_ack != '0)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_issue", {27'd0, tx_start, req_ack}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          start_cyc = cyc;
          check("tx_start", {31'd0, tx_start}, 32'd1);
          check("grant_id", {30'd0, grant_id}, {30'd0, e.id});
          check("tx_data", {24'd0, tx_data}, {24'd0, e.data});
          check("req_ack", {28'd0, req_ack}, 32'd1 << e.id);
          check("grant_valid", {31'd0, grant_valid}, 32'd1);
        end
      end
    end
  end

  initial begin
    #(uart_pkg::FRAME_CYCLES * 10);
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    rst = 1'b1; err_clr = 1'b0;
    clear_queues();
    repeat (3) @(posedge clk);
    #2;
    check("rst_grant_valid", {31'd0, grant_valid}, 32'd0);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_req_ack", {28'd0, req_ack}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_grant_id", {30'd0, grant_id}, 32'd0);
    check("rst_err", {31'd0, err_timeout}, 32'd0);
    rst = 1'b0;

    push_byte(0, 8'hA5, 1'b1);
    model_round();
    wait_idle(200);
    check("issue_latency", start_cyc - load_cyc, 32'd2);
    check("grant_id_hold", {30'd0, grant_id}, 32'd0);

    clear_queues();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 2; k++) push_byte(i, 8'(i * 16 + k), 1'b1);
    model_round();
    wait_idle(500);

    clear_queues();
    push_byte(0, 8'h11, 1'b0); push_byte(0, 8'h22, 1'b0); push_byte(0, 8'h33, 1'b1);
    push_byte(1, 8'h44, 1'b1);
    model_round();
    wait_idle(500);

    clear_queues();
    for (int k = 0; k < 6; k++) push_byte(0, 8'(8'h60 + k), 1'b0);
    push_byte(2, 8'h70, 1'b0); push_byte(2, 8'h71, 1'b1);
    model_round();
    wait_idle(500);

    for (int r = 0; r < 20; r++) begin
      clear_queues();
      for (int i = 0; i < N; i++)
        for (int k = $urandom_range(0, 5); k > 0; k--)
          push_byte(i, 8'($urandom), ($urandom_range(0, 2) == 0));
      model_round();
      wait_idle(2000);
    end

    tx_hang = 1'b1;
    clear_queues();
    push_byte(0, 8'h5A, 1'b1);
    model_round();
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(posedge clk); #2; n++; end
    check("midframe_start_seen", (n < 50) ? 32'd1 : 32'd0, 32'd1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2;
    check("midrst_tx_start", {31'd0, tx_start}, 32'd0);
    check("midrst_req_ack", {28'd0, req_ack}, 32'd0);
    check("midrst_tx_data", {24'd0, tx_data}, 32'd0);
    check("midrst_grant_valid", {31'd0, grant_valid}, 32'd0);
    check("midrst_grant_id", {30'd0, grant_id}, 32'd0);
    rst = 1'b0;
    mptr = 0;
    tx_done = 1'b1;
    @(posedge clk); #2 tx_done = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("stray_done_ignored", {31'd0, grant_valid}, 32'd0);

    clear_queues();
    push_byte(0, 8'hC3, 1'b1);
    push_byte(1, 8'h3C, 1'b1);
    model_round();
    for (int f = 0; f < 2; f++) begin
      n = 0;
      while (!tx_start && n < 50) begin @(posedge clk); #2; n++; end
      check("wd_start_seen", (n < 50) ? 32'd1 : 32'd0, 32'd1);
      n = 0;
      while (!err_timeout && n < 300) begin @(posedge clk); #2; n++; end
      check("wd_cycles", n, TIMEOUT);
      check("wd_release", {31'd0, grant_valid}, 32'd0);
      @(posedge clk); #2;
      check("err_sticky", {31'd0, err_timeout}, 32'd1);
      err_clr = 1'b1;
      @(posedge clk); #2 err_clr = 1'b0;
      check("err_clr", {31'd0, err_timeout}, 32'd0);
    end
    tx_hang = 1'b0;
    wait_idle(500);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
